// File: rtl/feature_list_collector.sv
// Feature list collector: records {row, col} of detector hits in a raster
// stream into a fixed-size list, with optional same-row spacing suppression.
module feature_list_collector #(
    parameter int unsigned IMG_W    = 160,
    parameter int unsigned MAX_FEAT = 10,
    parameter int unsigned CRD_W    = 12,
    parameter int unsigned MIN_SEP  = 0
) (
    input  logic                           clock,
    input  logic                           nReset,
    input  logic                           frameStart,
    input  logic                           inValid,
    input  logic                           isFeature,
    input  logic                           frameLast,
    input  logic                           doneAck,
    output logic [MAX_FEAT*2*CRD_W-1:0]    position,
    output logic [6:0]                     featCount,
    output logic                           overflow,
    output logic                           frameDone,
    output logic                           busy
);

    localparam int unsigned SLOT_W = 2 * CRD_W;
    localparam int unsigned POS_W  = MAX_FEAT * SLOT_W;
    localparam int unsigned CNT_W  = 7;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CRD_W-1:0]   col_q, col_d;
    logic [CRD_W-1:0]   row_q, row_d;
    logic [CRD_W-1:0]   last_col_q, last_col_d;
    logic               last_vld_q, last_vld_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               overflow_q, overflow_d;
    logic [POS_W-1:0]   position_q, position_d;
    logic               done_q, done_d;
    logic               busy_q, busy_d;

    logic [CRD_W-1:0]   col_gap_c;
    logic               sep_ok_c;
    logic               room_c;

    // Spacing test against the last kept column on the current row
    always_comb begin
        col_gap_c = col_q - last_col_q;
        sep_ok_c  = (MIN_SEP == 0) || !last_vld_q || (col_gap_c >= CRD_W'(MIN_SEP));
        room_c    = (count_q < CNT_W'(MAX_FEAT));
    end

    // Next-state, raster counters and list update
    always_comb begin
        state_d    = state_q;
        col_d      = col_q;
        row_d      = row_q;
        last_col_d = last_col_q;
        last_vld_d = last_vld_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        position_d = position_q;

        if (frameStart) begin
            state_d    = ST_COLLECT;
            col_d      = '0;
            row_d      = '0;
            last_vld_d = 1'b0;
            count_d    = '0;
            overflow_d = 1'b0;
        end else begin
            case (state_q)
                ST_COLLECT: begin
                    if (inValid) begin
                        if (isFeature && sep_ok_c) begin
                            if (room_c) begin
                                for (int unsigned k = 0; k < MAX_FEAT; k++) begin
                                    if (count_q == CNT_W'(k)) begin
                                        position_d[k*SLOT_W +: SLOT_W] = {row_q, col_q};
                                    end
                                end
                                count_d    = count_q + CNT_W'(1);
                                last_col_d = col_q;
                                last_vld_d = 1'b1;
                            end else begin
                                overflow_d = 1'b1;
                            end
                        end
                        // Row wrap forgets the last kept column, even one kept on this beat
                        if (col_q == CRD_W'(IMG_W - 1)) begin
                            col_d      = '0;
                            last_vld_d = 1'b0;
                            if (row_q != {CRD_W{1'b1}}) begin
                                row_d = row_q + CRD_W'(1);
                            end
                        end else begin
                            col_d = col_q + CRD_W'(1);
                        end
                        if (frameLast) begin
                            state_d = ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    if (doneAck) begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end

        busy_d = (state_d == ST_COLLECT);
        done_d = (state_d == ST_DONE);
    end

    // State and datapath registers
    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            state_q    <= ST_IDLE;
            col_q      <= '0;
            row_q      <= '0;
            last_col_q <= '0;
            last_vld_q <= 1'b0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            position_q <= '0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            col_q      <= col_d;
            row_q      <= row_d;
            last_col_q <= last_col_d;
            last_vld_q <= last_vld_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            position_q <= position_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
        end
    end

    assign position  = position_q;
    assign featCount = count_q;
    assign overflow  = overflow_q;
    assign frameDone = done_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_feature_list_collector.sv
// Directed bench for feature_list_collector; four parameterisations share one stimulus.
module tb_feature_list_collector;

    logic clock = 1'b0;
    logic nReset = 1'b0;
    logic frameStart = 1'b0;
    logic inValid = 1'b0;
    logic isFeature = 1'b0;
    logic frameLast = 1'b0;
    logic doneAck = 1'b0;

    // dut0: 160 wide, 10 slots; dut1: 4 wide, 10 slots; dut2: 4 wide, 2 slots; dut3: 8 wide, 4 slots, MIN_SEP=3
    logic [239:0] pos0, pos1;
    logic [47:0]  pos2;
    logic [95:0]  pos3;
    logic [6:0]   cnt0, cnt1, cnt2, cnt3;
    logic         ovf0, ovf1, ovf2, ovf3;
    logic         done0, done1, done2, done3;
    logic         busy0, busy1, busy2, busy3;

    int n_chk = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    feature_list_collector #(.IMG_W(160), .MAX_FEAT(10), .CRD_W(12), .MIN_SEP(0)) u_dut0 (
        .clock(clock), .nReset(nReset), .frameStart(frameStart), .inValid(inValid),
        .isFeature(isFeature), .frameLast(frameLast), .doneAck(doneAck),
        .position(pos0), .featCount(cnt0), .overflow(ovf0), .frameDone(done0), .busy(busy0));

    feature_list_collector #(.IMG_W(4), .MAX_FEAT(10), .CRD_W(12), .MIN_SEP(0)) u_dut1 (
        .clock(clock), .nReset(nReset), .frameStart(frameStart), .inValid(inValid),
        .isFeature(isFeature), .frameLast(frameLast), .doneAck(doneAck),
        .position(pos1), .featCount(cnt1), .overflow(ovf1), .frameDone(done1), .busy(busy1));

    feature_list_collector #(.IMG_W(4), .MAX_FEAT(2), .CRD_W(12), .MIN_SEP(0)) u_dut2 (
        .clock(clock), .nReset(nReset), .frameStart(frameStart), .inValid(inValid),
        .isFeature(isFeature), .frameLast(frameLast), .doneAck(doneAck),
        .position(pos2), .featCount(cnt2), .overflow(ovf2), .frameDone(done2), .busy(busy2));

    feature_list_collector #(.IMG_W(8), .MAX_FEAT(4), .CRD_W(12), .MIN_SEP(3)) u_dut3 (
        .clock(clock), .nReset(nReset), .frameStart(frameStart), .inValid(inValid),
        .isFeature(isFeature), .frameLast(frameLast), .doneAck(doneAck),
        .position(pos3), .featCount(cnt3), .overflow(ovf3), .frameDone(done3), .busy(busy3));

    typedef struct {
        logic       feat;
        logic       last;
        logic       ack;
        logic [6:0] cnt1;
        logic [6:0] cnt2;
        logic       busy1;
        logic       done1;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input logic [239:0] act, input logic [239:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic beat(input logic feat, input logic last);
        inValid   = 1'b1;
        isFeature = feat;
        frameLast = last;
        tick();
        inValid   = 1'b0;
        isFeature = 1'b0;
        frameLast = 1'b0;
    endtask

    function automatic logic [23:0] rc(input int r, input int c);
        return {12'(r), 12'(c)};
    endfunction

    initial begin
        // feat last ack cnt1 cnt2 busy1 done1
        vecs[0]  = '{1'b0, 1'b0, 1'b0, 7'd0, 7'd0, 1'b1, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 7'd1, 7'd1, 1'b1, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 7'd1, 7'd1, 1'b1, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 1'b1, 7'd1, 7'd1, 1'b1, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 7'd1, 7'd1, 1'b1, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 7'd1, 7'd1, 1'b1, 1'b0};
        vecs[6]  = '{1'b1, 1'b0, 1'b0, 7'd2, 7'd2, 1'b1, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 7'd2, 7'd2, 1'b1, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 7'd2, 7'd2, 1'b1, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 7'd2, 7'd2, 1'b1, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 7'd2, 7'd2, 1'b1, 1'b0};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 7'd2, 7'd2, 1'b1, 1'b0};
        vecs[12] = '{1'b0, 1'b0, 1'b0, 7'd2, 7'd2, 1'b1, 1'b0};
        vecs[13] = '{1'b0, 1'b0, 1'b0, 7'd2, 7'd2, 1'b1, 1'b0};
        vecs[14] = '{1'b0, 1'b0, 1'b0, 7'd2, 7'd2, 1'b1, 1'b0};
        vecs[15] = '{1'b1, 1'b1, 1'b0, 7'd3, 7'd2, 1'b0, 1'b1};

        // Reset values
        tick();
        tick();
        check("rst_pos0", pos0, 240'd0);
        check("rst_cnt0", 240'(cnt0), 240'd0);
        check("rst_flags0", 240'({ovf0, done0, busy0}), 240'd0);
        nReset = 1'b1;
        tick();

        // Beats in IDLE are ignored
        beat(1'b1, 1'b0);
        beat(1'b1, 1'b1);
        check("idle_cnt1", 240'(cnt1), 240'd0);
        check("idle_busy1", 240'({busy1, done1}), 240'd0);

        // frameStart with a feature beat: beat ignored, block enters COLLECT
        frameStart = 1'b1;
        inValid    = 1'b1;
        isFeature  = 1'b1;
        tick();
        frameStart = 1'b0;
        inValid    = 1'b0;
        isFeature  = 1'b0;
        check("fs_busy1", 240'(busy1), 240'd1);
        check("fs_cnt1", 240'(cnt1), 240'd0);

        // 16-beat frame on the 4-wide instances
        for (int i = 0; i < 16; i++) begin
            doneAck = vecs[i].ack;
            beat(vecs[i].feat, vecs[i].last);
            doneAck = 1'b0;
            check($sformatf("v%0d_cnt1", i), 240'(cnt1), 240'(vecs[i].cnt1));
            check($sformatf("v%0d_cnt2", i), 240'(cnt2), 240'(vecs[i].cnt2));
            check($sformatf("v%0d_busy1", i), 240'(busy1), 240'(vecs[i].busy1));
            check($sformatf("v%0d_done1", i), 240'(done1), 240'(vecs[i].done1));
        end
        check("f1_slot0", 240'(pos1[23:0]), 240'(rc(0, 1)));
        check("f1_slot1", 240'(pos1[47:24]), 240'(rc(1, 2)));
        check("f1_slot2", 240'(pos1[71:48]), 240'(rc(3, 3)));
        check("f1_ovf", 240'(ovf1), 240'd0);
        check("f2_ovf", 240'(ovf2), 240'd1);
        check("f2_slot0", 240'(pos2[23:0]), 240'(rc(0, 1)));
        check("f2_slot1", 240'(pos2[47:24]), 240'(rc(1, 2)));

        // DONE holds against further beats
        beat(1'b1, 1'b0);
        beat(1'b1, 1'b1);
        check("done_hold_cnt1", 240'(cnt1), 240'd3);
        check("done_hold_done1", 240'({done1, busy1}), 240'b10);

        // doneAck releases to IDLE, list retained
        doneAck = 1'b1;
        tick();
        doneAck = 1'b0;
        check("ack_flags1", 240'({done1, busy1}), 240'd0);
        check("ack_cnt1", 240'(cnt1), 240'd3);
        check("ack_slot1", 240'(pos1[47:24]), 240'(rc(1, 2)));

        // MIN_SEP frame on the 8-wide instance
        frameStart = 1'b1;
        tick();
        frameStart = 1'b0;
        for (int i = 0; i < 10; i++) begin
            beat((i == 0) || (i == 2) || (i == 3) || (i == 9), i == 9);
        end
        check("sep_cnt3", 240'(cnt3), 240'd3);
        check("sep_slot0", 240'(pos3[23:0]), 240'(rc(0, 0)));
        check("sep_slot1", 240'(pos3[47:24]), 240'(rc(0, 3)));
        check("sep_slot2", 240'(pos3[71:48]), 240'(rc(1, 1)));
        check("sep_ovf3", 240'(ovf3), 240'd0);
        check("sep_done3", 240'(done3), 240'd1);
        check("sep_ovf2", 240'(ovf2), 240'd1);

        // frameStart beats doneAck in DONE
        frameStart = 1'b1;
        doneAck    = 1'b1;
        tick();
        frameStart = 1'b0;
        doneAck    = 1'b0;
        check("fsack_busy3", 240'(busy3), 240'd1);
        check("fsack_done3", 240'(done3), 240'd0);
        check("fsack_cnt3", 240'(cnt3), 240'd0);
        check("fsack_ovf2", 240'(ovf2), 240'd0);

        // Mid-frame asynchronous reset
        for (int i = 0; i < 5; i++) begin
            beat((i == 0) || (i == 2), 1'b0);
        end
        check("pre_rst_cnt0", 240'(cnt0), 240'd2);
        nReset = 1'b0;
        #1;
        check("arst_pos0", pos0, 240'd0);
        check("arst_cnt0", 240'(cnt0), 240'd0);
        check("arst_flags0", 240'({ovf0, done0, busy0}), 240'd0);
        #2;
        nReset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            beat(1'b1, 1'b0);
        end
        check("post_rst_cnt0", 240'(cnt0), 240'd0);
        check("post_rst_busy0", 240'(busy0), 240'd0);

        // Full 160x120 frame, continuous beats, feature every 97th pixel
        frameStart = 1'b1;
        tick();
        frameStart = 1'b0;
        for (int i = 0; i < 19200; i++) begin
            if (i == 19199) begin
                check("big_pre_done0", 240'({done0, busy0}), 240'b01);
            end
            inValid   = 1'b1;
            isFeature = ((i % 97) == 96);
            frameLast = (i == 19199);
            tick();
        end
        inValid   = 1'b0;
        isFeature = 1'b0;
        frameLast = 1'b0;
        check("big_done0", 240'({done0, busy0}), 240'b10);
        check("big_cnt0", 240'(cnt0), 240'd10);
        check("big_ovf0", 240'(ovf0), 240'd1);
        for (int k = 0; k < 10; k++) begin
            int idx;
            idx = 97 * k + 96;
            check($sformatf("big_slot%0d", k), 240'(pos0[k*24 +: 24]), 240'(rc(idx / 160, idx % 160)));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/feature_list_collector.md
FEATURE_LIST_COLLECTOR -- requirements
Module: feature_list_collector

Interface
REQ-001 SHALL have parameter IMG_W, default 160: pixels per image row, range 2..4095.
REQ-002 SHALL have parameter MAX_FEAT, default 10: feature slots in the list, range 1..64.
REQ-003 SHALL have parameter CRD_W, default 12: bit width of each row and column coordinate.
REQ-004 SHALL have parameter MIN_SEP, default 0: minimum column gap between kept features on the same row; 0 disables suppression.
REQ-005 clock  in  1  single clock; all logic SHALL be rising-edge.
REQ-006 nReset  in  1  asynchronous, active-low reset.
REQ-007 frameStart  in  1  single-cycle pulse that starts a new frame.
REQ-008 inValid  in  1  qualifies isFeature for one pixel beat.
REQ-009 isFeature  in  1  detector flag for the current raster pixel.
REQ-010 frameLast  in  1  marks the last pixel of a frame; only meaningful with inValid.
REQ-011 doneAck  in  1  consumer releases the completed list.
REQ-012 position  out  MAX_FEAT*2*CRD_W  packed list; slot k = bits [(k+1)*2*CRD_W-1 : k*2*CRD_W] = {row, col}.
REQ-013 featCount  out  7  number of valid slots, 0..MAX_FEAT.
REQ-014 overflow  out  1  a feature was dropped because the list was full.
REQ-015 frameDone  out  1  list is complete and stable.
REQ-016 busy  out  1  high in COLLECT.

Function
REQ-017 SHALL implement the states IDLE, COLLECT and DONE.
REQ-018 frameStart in any state SHALL, next cycle, clear col, row, featCount and overflow, and enter COLLECT; position contents need not be cleared, and slots >= featCount are don't-care.
REQ-019 In COLLECT, each inValid beat SHALL advance col; at col==IMG_W-1, col wraps to 0 and row increments; row saturates at 2^CRD_W-1.
REQ-020 A beat with inValid & isFeature SHALL be kept when both conditions hold: (a) featCount<MAX_FEAT; (b) MIN_SEP==0, OR no feature is kept yet on the current row, OR col - lastKeptCol >= MIN_SEP.
REQ-021 A kept feature SHALL write {row, col} of that beat into slot featCount, and featCount SHALL increment on the next edge (1-cycle latency).
REQ-022 A feature that passes the MIN_SEP check while featCount==MAX_FEAT SHALL set overflow, which remains sticky until the next frameStart; a feature that fails the MIN_SEP check SHALL be discarded silently.
REQ-023 lastKeptCol validity SHALL reset on every row wrap.
REQ-024 inValid & frameLast in COLLECT SHALL process the beat normally and then enter DONE on the same edge.
REQ-025 In DONE, frameDone=1, position, featCount and overflow SHALL hold stable, and inValid SHALL be ignored.
REQ-026 doneAck in DONE SHALL return the block to IDLE next cycle with frameDone=0; the list contents SHALL be retained.
REQ-027 In IDLE and DONE, inValid, isFeature and frameLast SHALL be ignored.
REQ-028 frameStart and doneAck in the same cycle: frameStart SHALL win.
REQ-029 frameStart and inValid in the same cycle: the beat SHALL be ignored, and the first counted pixel is the next inValid beat.
REQ-030 doneAck outside DONE SHALL have no effect.
REQ-031 busy SHALL be 1 exactly when the state is COLLECT.

Reset
REQ-032 On nReset=0, immediately and asynchronously: state=IDLE, position=0, featCount=0, overflow=0, frameDone=0, busy=0, col=0, row=0.
REQ-033 Reset asserted mid-COLLECT SHALL discard the partial frame; after release the block stays in IDLE until frameStart.
REQ-034 All outputs SHALL be registered.

Verification
REQ-035 IMG_W=4, MAX_FEAT=10: frameStart, then 16 beats with isFeature at indices 1, 6, 15 and frameLast on 15 -> featCount=3, slots = {0,1}, {1,2}, {3,3}, frameDone=1, overflow=0.
REQ-036 MAX_FEAT=2: three features in one frame -> featCount=2, overflow=1; the third feature is not written.
REQ-037 MIN_SEP=3, IMG_W=8: features at cols 0, 2, 3 of row 0 and col 1 of row 1 -> kept {0,0}, {0,3}, {1,1}; overflow=0.
REQ-038 nReset pulsed low after 5 beats mid-frame -> all outputs 0 within the reset cycle; later inValid beats ignored until frameStart.
REQ-039 DONE with frameStart and doneAck high in the same cycle -> COLLECT next cycle, featCount=0, frameDone=0, busy=1.
REQ-040 Continuous inValid with no gaps, 160x120 frame with a feature every 97th pixel -> featCount=10, overflow=1, frameDone asserted one cycle after the frameLast beat.
